if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 16 +
 rtl/if_id_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared processor constants for the fetch/decode boundary.
// Widths, reset PC, immediate-flag bit, NOP word and buffer states.
package if_id_buffer_pkg;

    localparam int          INSTR_W  = 16;
    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'd32;
    localparam int          IMM_BIT  = 15;
    localparam logic [15:0] NOP      = 16'h0000;

    typedef enum logic {
        S_OPCODE = 1'b0,
        S_IMM    = 1'b1
    } state_e;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: assembles one- or two-word instructions
// from the fetch stream and presents them to decode.
module if_id_buffer #(
    parameter int              INSTR_W  = if_id_buffer_pkg::INSTR_W,
    parameter int              PC_W     = if_id_buffer_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(if_id_buffer_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               fetch_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] ir_out,
    output logic [INSTR_W-1:0] imm_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               fetch_hold
);

    import if_id_buffer_pkg::*;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] pend_ir_q, pend_ir_d;
    logic [PC_W-1:0]    pend_pc_q, pend_pc_d;

    assign fetch_hold = stall & ~flush;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        pend_ir_d = pend_ir_q;
        pend_pc_d = pend_pc_q;
        if (flush) begin
            // pc_out keeps its last value; only the instruction is squashed
            state_d   = S_OPCODE;
            ir_d      = INSTR_W'(NOP);
            imm_d     = '0;
            valid_d   = 1'b0;
            pend_ir_d = '0;
            pend_pc_d = '0;
        end else if (stall) begin
            state_d = state_q;
        end else if (!fetch_valid) begin
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_OPCODE: begin
                    if (instr_in[IMM_BIT]) begin
                        pend_ir_d = instr_in;
                        pend_pc_d = pc_in;
                        valid_d   = 1'b0;
                        state_d   = S_IMM;
                    end else begin
                        ir_d    = instr_in;
                        pc_d    = pc_in;
                        imm_d   = '0;
                        valid_d = 1'b1;
                    end
                end
                S_IMM: begin
                    ir_d    = pend_ir_q;
                    pc_d    = pend_pc_q;
                    imm_d   = instr_in;
                    valid_d = 1'b1;
                    state_d = S_OPCODE;
                end
                default: state_d = S_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_OPCODE;
            ir_q      <= '0;
            imm_q     <= '0;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            pend_ir_q <= '0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            pend_ir_q <= pend_ir_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign ir_out    = ir_q;
    assign imm_out   = imm_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

endmodule
